// File: rtl/interconn_pkg.sv
// Shared types and widths for the interconnect receive path.
package interconn_pkg;

  localparam int N     = 8;
  localparam int W     = 64;
  localparam int BADDR = 15;

  typedef struct packed {
    logic [BADDR-1:0] addr;
    logic [W-1:0]     word;
    logic [N-1:0]     from;
  } recv_entry_t;

  // True when exactly one bit of the source vector is set.
  function automatic logic is_onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

endpackage

// File: rtl/interconn_recv_buf_if.sv
// Receive-side bus: interconnect slice in, MVU data-memory write port out.
interface interconn_recv_buf_if;

  logic                            in_en;
  logic [interconn_pkg::BADDR-1:0] in_addr;
  logic [interconn_pkg::W-1:0]     in_word;
  logic [interconn_pkg::N-1:0]     in_from;
  logic                            mem_busy;
  logic                            mem_we;
  logic [interconn_pkg::BADDR-1:0] mem_addr;
  logic [interconn_pkg::W-1:0]     mem_word;
  logic [interconn_pkg::N-1:0]     mem_from;

  modport master (
    output in_en, in_addr, in_word, in_from, mem_busy,
    input  mem_we, mem_addr, mem_word, mem_from
  );

  modport slave (
    input  in_en, in_addr, in_word, in_from, mem_busy,
    output mem_we, mem_addr, mem_word, mem_from
  );

endinterface

// File: rtl/interconn_fifo.sv
// Small synchronous FIFO of received entries; occupancy is tracked explicitly
// so full/empty never depend on pointer comparison.
module interconn_fifo
  import interconn_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          push,
  input  logic          pop,
  input  recv_entry_t   wr_data,
  output recv_entry_t   rd_data,
  output logic [LW-1:0] level
);

  recv_entry_t   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // NOTE: storage is not reset; level=0 already marks every entry invalid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  assign rd_data = mem[rptr];

endmodule

// File: rtl/interconn_recv_buf.sv
// Buffers interconnect words and drains them into MVU data memory whenever
// the local write-back leaves the port free; tracks drops and bad sources.
module interconn_recv_buf
  import interconn_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNTW  = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 clr_n,
  interconn_recv_buf_if.slave  bus,
  input  logic                 err_clr,
  output logic [LW-1:0]        level,
  output logic                 ovf,
  output logic                 src_err,
  output logic [CNTW-1:0]      rx_cnt
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic        full;
  logic        pop;
  logic        push;
  recv_entry_t in_entry;
  recv_entry_t head;
  recv_entry_t out_q;
  logic        we_q;

  // A full FIFO still accepts when the head leaves at the same edge.
  assign full     = (level == FULL_LVL);
  assign pop      = (level != '0) && !bus.mem_busy;
  assign push     = bus.in_en && (!full || pop);
  assign in_entry = '{addr: bus.in_addr, word: bus.in_word, from: bus.in_from};

  interconn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .clr_n   (clr_n),
    .push    (push),
    .pop     (pop),
    .wr_data (in_entry),
    .rd_data (head),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      we_q    <= 1'b0;
      out_q   <= '0;
      ovf     <= 1'b0;
      src_err <= 1'b0;
      rx_cnt  <= '0;
    end else begin
      we_q <= pop;
      if (pop) out_q <= head;

      // A new error in the same cycle as err_clr must not be lost.
      if (bus.in_en && !push) ovf <= 1'b1;
      else if (err_clr)       ovf <= 1'b0;

      if (bus.in_en && !is_onehot(bus.in_from)) src_err <= 1'b1;
      else if (err_clr)                         src_err <= 1'b0;

      if (push && (rx_cnt != '1)) rx_cnt <= rx_cnt + CNTW'(1);
    end
  end

  assign bus.mem_we   = we_q;
  assign bus.mem_addr = out_q.addr;
  assign bus.mem_word = out_q.word;
  assign bus.mem_from = out_q.from;

endmodule
